// File: rtl/router_pkg.sv
// Router-wide default dimensions and index types shared by the allocator and its users.
package router_pkg;
  localparam int NUM_PORTS_DEF    = 4;
  localparam int NUM_VC_DEF       = 4;
  localparam int CREDIT_DEPTH_DEF = 4;

  typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;
  typedef logic [$clog2(NUM_VC_DEF)-1:0]    vc_idx_t;
endpackage

// File: rtl/switch_allocator_if.sv
// Request/credit inputs and crossbar-select outputs of the switch allocator.
interface switch_allocator_if
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int NUM_VC    = NUM_VC_DEF
) ();
  logic [NUM_PORTS-1:0][NUM_VC-1:0]                 req_valid;
  logic [NUM_PORTS-1:0][NUM_VC-1:0][NUM_PORTS-1:0]  req_outport;
  logic [NUM_PORTS-1:0]                             credit_return;
  logic [NUM_PORTS-1:0][NUM_VC-1:0][NUM_PORTS-1:0]  vc_mapping;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]                 grant;

  modport master (
    output req_valid, req_outport, credit_return,
    input  vc_mapping, grant
  );

  modport slave (
    input  req_valid, req_outport, credit_return,
    output vc_mapping, grant
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i (wrapping), one-hot out.
module rr_arbiter #(
  parameter  int WIDTH = 4,
  localparam int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [WIDTH-1:0] gnt_o
);
  localparam logic [PW:0] WIDTH_L = (PW+1)'(WIDTH);

  logic [PW:0] idx_sum;
  logic        found;

  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    idx_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx_sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (idx_sum >= WIDTH_L) idx_sum = idx_sum - WIDTH_L;
      if (!found && req_i[idx_sum[PW-1:0]]) begin
        gnt_o[idx_sum[PW-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator (VC round-robin per input, then input round-robin per output); registered, 1-cycle latency.
// Backpressure only through per-output downstream credits when SA_CREDIT_CHECK_EN is defined; otherwise every output is always available.
module switch_allocator
  import router_pkg::*;
#(
  parameter int NUM_PORTS    = NUM_PORTS_DEF,
  parameter int NUM_VC       = NUM_VC_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_allocator_if.slave bus
);
  localparam int PPW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int VPW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef logic [NUM_PORTS-1:0] pmask_t;

  pmask_t [NUM_PORTS-1:0][NUM_VC-1:0] tgt, map_d, map_q;
  logic   [NUM_PORTS-1:0][NUM_VC-1:0] elig, s1_gnt, grant_d, grant_q;
  pmask_t [NUM_PORTS-1:0]             s1_tgt, s2_req, s2_gnt;
  pmask_t                             cred_ok;
  logic   [NUM_PORTS-1:0][VPW-1:0]    in_ptr_d, in_ptr_q;
  logic   [NUM_PORTS-1:0][PPW-1:0]    out_ptr_d, out_ptr_q;

  // Multi-hot targets collapse to their lowest set bit; all-zero targets never qualify.
  always_comb begin
    tgt  = '0;
    elig = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int k = 0; k < NUM_VC; k++) begin
        tgt[j][k]  = bus.req_outport[j][k] & (~bus.req_outport[j][k] + pmask_t'(1));
        elig[j][k] = bus.req_valid[j][k] & (|(tgt[j][k] & cred_ok));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_in_arb
    rr_arbiter #(.WIDTH(NUM_VC)) u_in_arb (
      .req_i (elig[j]),
      .ptr_i (in_ptr_q[j]),
      .gnt_o (s1_gnt[j])
    );
  end

  always_comb begin
    s1_tgt = '0;
    s2_req = '0;
    for (int j = 0; j < NUM_PORTS; j++)
      for (int k = 0; k < NUM_VC; k++)
        if (s1_gnt[j][k]) s1_tgt[j] = tgt[j][k];
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = 0; j < NUM_PORTS; j++)
        s2_req[i][j] = s1_tgt[j][i];
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_out_arb
    rr_arbiter #(.WIDTH(NUM_PORTS)) u_out_arb (
      .req_i (s2_req[i]),
      .ptr_i (out_ptr_q[i]),
      .gnt_o (s2_gnt[i])
    );
  end

  // Pointers move only on a final grant, so a stage-1 winner that loses stage 2 retries first next cycle.
  always_comb begin
    map_d     = '0;
    grant_d   = '0;
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    for (int j = 0; j < NUM_PORTS; j++)
      for (int k = 0; k < NUM_VC; k++)
        for (int i = 0; i < NUM_PORTS; i++)
          map_d[j][k][i] = s1_gnt[j][k] & s2_gnt[i][j];
    for (int j = 0; j < NUM_PORTS; j++)
      for (int k = 0; k < NUM_VC; k++) begin
        grant_d[j][k] = |map_d[j][k];
        if (grant_d[j][k]) in_ptr_d[j] = VPW'((k + 1) % NUM_VC);
      end
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = 0; j < NUM_PORTS; j++)
        if (s2_gnt[i][j]) out_ptr_d[i] = PPW'((j + 1) % NUM_PORTS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q     <= '0;
      grant_q   <= '0;
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
    end else begin
      map_q     <= map_d;
      grant_q   <= grant_d;
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
    end
  end

`ifdef SA_CREDIT_CHECK_EN
  localparam int            CW        = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_DEPTH);

  logic [NUM_PORTS-1:0][CW-1:0] cred_d, cred_q;

  always_comb begin
    cred_ok = '0;
    for (int i = 0; i < NUM_PORTS; i++) cred_ok[i] = (cred_q[i] != '0);
  end

  // A grant and a return in the same cycle cancel; returns beyond full are dropped.
  always_comb begin
    cred_d = cred_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((|s2_gnt[i]) && !bus.credit_return[i])
        cred_d[i] = cred_q[i] - CW'(1);
      else if (!(|s2_gnt[i]) && bus.credit_return[i] && (cred_q[i] != CRED_FULL))
        cred_d[i] = cred_q[i] + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cred_q <= {NUM_PORTS{CRED_FULL}};
    else        cred_q <= cred_d;
  end
`else
  localparam int unused_credit_depth = CREDIT_DEPTH;
  logic          unused_credit_return;

  assign cred_ok              = '1;
  assign unused_credit_return = ^bus.credit_return;
`endif

  assign bus.vc_mapping = map_q;
  assign bus.grant      = grant_q;
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of router input and output ports.
REQ-002 SHALL have parameter NUM_VC, default 4: virtual channels per input port.
REQ-003 SHALL have parameter CREDIT_DEPTH, default 4: downstream buffer slots per output port.
REQ-004 SHALL have port clk  input  1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  [NUM_PORTS][NUM_VC] x 1: input VC has a flit ready for switch traversal.
REQ-007 SHALL have port req_outport  input  [NUM_PORTS][NUM_VC] x NUM_PORTS: one-hot target output port per input VC.
REQ-008 SHALL have port credit_return  input  NUM_PORTS: one credit returned per output port per cycle.
REQ-009 SHALL have port vc_mapping  output  [NUM_PORTS][NUM_VC] x NUM_PORTS: registered crossbar select; bit [j][k][i] set means input j VC k drives output i.
REQ-010 SHALL have port grant  output  [NUM_PORTS][NUM_VC] x 1: registered; equals the OR-reduction of vc_mapping[j][k].

Function
REQ-011 SHALL sample requests in cycle N and present the resulting vc_mapping and grant in cycle N+1 (one-cycle latency, registered outputs).
REQ-012 SHALL treat an input VC as eligible when req_valid is 1, req_outport is non-zero and the target output passes the credit check (REQ-024).
REQ-013 SHALL use the lowest set bit of a multi-hot req_outport as the target.
REQ-014 SHALL ignore a request whose req_outport is all-zero; it never produces a grant.
REQ-015 Stage 1 SHALL let each input port pick one eligible VC by round-robin, starting from that port's input pointer.
REQ-016 Stage 2 SHALL let each output port pick one stage-1 winner targeting it by round-robin, starting from that output's pointer.
REQ-017 SHALL set vc_mapping[j][k][i] only when input j picked VC k in stage 1 and output i picked input j in stage 2.
REQ-018 SHALL guarantee at most one set bit per output column and at most one granted VC per input port.
REQ-019 SHALL advance an input pointer to (winning VC + 1) mod NUM_VC only when that input receives a final grant; a stage-1 winner that loses stage 2 SHALL leave the pointer unchanged.
REQ-020 SHALL advance an output pointer to (winning input + 1) mod NUM_PORTS only on a grant at that output.
REQ-021 SHALL drive vc_mapping and grant to all-zero in any cycle after a sample with no eligible requests.
REQ-022 SHALL evaluate each cycle independently; a requester holding req_valid simply re-competes.

Reset
REQ-023 While rst_n is 0 the block SHALL immediately clear vc_mapping and grant, reset all pointers to 0, reset credit counters to CREDIT_DEPTH, and discard any in-flight allocation; on deassertion the first grant SHALL appear no earlier than the cycle after the first sampling edge.

Configuration
REQ-024 With SA_CREDIT_CHECK_EN defined, the block SHALL keep a per-output credit counter of width $clog2(CREDIT_DEPTH+1). A target output SHALL be eligible only when its count is greater than 0. Each grant SHALL decrement the count, each credit_return SHALL increment it, and a grant plus a return in the same cycle SHALL leave it unchanged. A return while the count is already CREDIT_DEPTH SHALL be ignored (saturate).
REQ-025 Without SA_CREDIT_CHECK_EN, the block SHALL have no credit counters, every output SHALL always pass the credit check, and credit_return SHALL be ignored.

Structure
REQ-026 The NUM_PORTS/NUM_VC defaults and the port-index and VC-index typedefs SHALL live in shared package router_pkg.
REQ-027 Round-robin selection SHALL be a parameterised sub-module rr_arbiter (width, req, pointer in, one-hot grant out), instantiated NUM_PORTS times per stage.

Verification
REQ-028 The bench SHALL cover a single request: input 1 VC 2 requests output 3 -> the next cycle vc_mapping[1][2]=4'b1000 and grant[1][2]=1, all other bits 0.
REQ-029 The bench SHALL cover input-side round-robin: input 0 VCs 0-3 all request output 2 and are held for 4 cycles -> grants rotate VC0, VC1, VC2, VC3.
REQ-030 The bench SHALL cover an output conflict: inputs 0-3 VC0 all request output 1 and are held -> output 1 grants inputs 0, 1, 2, 3 in successive cycles, one per cycle.
REQ-031 The bench SHALL cover pointer hold on stage-2 loss: inputs 0 and 1 request output 0, and input 1 also has VC1 to output 2 -> the input 1 pointer moves only on its actual grant.
REQ-032 The bench SHALL cover credits with SA_CREDIT_CHECK_EN and CREDIT_DEPTH=2: 3 back-to-back requests to output 0 with no returns -> 2 grants then stall; one credit_return[0] -> exactly 1 more grant.
REQ-033 The bench SHALL cover reset mid-traffic: assert rst_n=0 while grants are active -> outputs are 0 asynchronously and the first post-reset grant goes to VC0/input 0 pointer order.
